cpu_loader_ctrl: RTL and testbench

Command sequencer in front of the CPU subsystem. Consumes a byte stream (host link receive side), loads programs into instruction memory through the imem write port, and controls CPU execution: run, single-step, halt-abort and CPU reset. Sits between the receive byte interface and the cpu_subsystem `i_imem_*` / `i_mem_wsize` / `i_en` inputs.

---
 rtl/cpu_loader_ctrl_pkg.sv | 29 ++
 rtl/cpu_loader_ctrl_if.sv | 25 ++
 rtl/cpu_loader_ctrl_word_asm.sv | 45 ++++
 rtl/cpu_loader_ctrl.sv | 174 +++++++++++++++++
 tb/tb_cpu_loader_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_loader_ctrl_pkg.sv
// Shared types and constants for the CPU loader/sequencer.
// States, command bytes and the imem write size.
package cpu_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_CNT,
      LOAD_DATA,
      WRITE,
      RUN,
      STEP,
      CPU_RST
   } state_t;

   localparam logic [7:0] CMD_LOAD = 8'h4C;
   localparam logic [7:0] CMD_RUN  = 8'h43;
   localparam logic [7:0] CMD_STEP = 8'h53;
   localparam logic [7:0] CMD_RST  = 8'h52;
   localparam logic [7:0] CMD_HALT = 8'h48;

   localparam logic [1:0] WSIZE_WORD = 2'b10;

   // Word count is legal when 1 <= n <= program depth.
   function automatic logic cnt_ok(input logic [7:0] n,
                                   input int depth);
      return (n != 8'd0) && (int'(n) <= depth);
   endfunction

endpackage

// File: rtl/cpu_loader_ctrl_if.sv
// Receive-byte and imem write-port bundle.
// master = loader side, slave = link/memory side.
interface cpu_loader_ctrl_if #(
   parameter int NB_DATA         = 32,
   parameter int IMEM_ADDR_WIDTH = 5
);
   logic [7:0]                 i_rx_data;
   logic                       i_rx_valid;
   logic [NB_DATA-1:0]         o_imem_data;
   logic [IMEM_ADDR_WIDTH-1:0] o_imem_waddr;
   logic                       o_imem_wen;
   logic [1:0]                 o_mem_wsize;

   modport master (
      input  i_rx_data, i_rx_valid,
      output o_imem_data, o_imem_waddr,
      output o_imem_wen, o_mem_wsize
   );

   modport slave (
      output i_rx_data, i_rx_valid,
      input  o_imem_data, o_imem_waddr,
      input  o_imem_wen, o_mem_wsize
   );
endinterface

// File: rtl/cpu_loader_ctrl_word_asm.sv
// Byte-to-word assembler, LSB first.
// o_word is the register with the incoming byte merged in.
module cpu_loader_word_asm #(
   parameter int NB_DATA = 32
) (
   input  logic               clk,
   input  logic               i_rst_n,
   input  logic               i_clr,
   input  logic               i_push,
   input  logic [7:0]         i_byte,
   output logic [NB_DATA-1:0] o_word,
   output logic               o_word_ready
);
   localparam int NBYTES = NB_DATA / 8;
   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   logic [IW-1:0]      r_idx;
   logic [NB_DATA-1:0] r_word;
   logic               w_last;

   assign w_last       = (r_idx == IW'(NBYTES - 1));
   assign o_word_ready = i_push && w_last;

   // Merge the current byte into its lane.
   always_comb begin
      o_word = r_word;
      for (int k = 0; k < NBYTES; k++) begin
         if (r_idx == IW'(k)) o_word[8*k +: 8] = i_byte;
      end
   end

   // Byte index and word register.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_idx  <= '0;
         r_word <= '0;
      end else if (i_clr) begin
         r_idx  <= '0;
      end else if (i_push) begin
         r_word <= o_word;
         r_idx  <= w_last ? '0 : r_idx + IW'(1);
      end
   end

endmodule

// File: rtl/cpu_loader_ctrl.sv
// Command sequencer: program load into imem and
// run / step / halt-abort / reset control of the CPU.
module cpu_loader_ctrl
   import cpu_loader_pkg::*;
#(
   parameter int NB_DATA         = 32,
   parameter int IMEM_ADDR_WIDTH = 5,
   parameter int RST_CYCLES      = 4
) (
   input  logic              clk,
   input  logic              i_rst_n,
   cpu_loader_ctrl_if.master bus,
   input  logic              i_cpu_halt,
   output logic              o_cpu_en,
   output logic              o_cpu_rst,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err
);
   localparam int DEPTH = 1 << IMEM_ADDR_WIDTH;
   localparam int CW    = IMEM_ADDR_WIDTH + 1;
   localparam int RW    = $clog2(RST_CYCLES) + 1;

   state_t                     r_state;
   state_t                     w_next;
   logic [CW-1:0]              r_n;
   logic [CW-1:0]              r_wcnt;
   logic [RW-1:0]              r_rcnt;
   logic [NB_DATA-1:0]         r_imem_data;
   logic [IMEM_ADDR_WIDTH-1:0] r_imem_waddr;
   logic                       r_done;
   logic                       r_err;

   logic               w_valid;
   logic [7:0]         w_byte;
   logic               w_done;
   logic               w_err;
   logic               w_push;
   logic               w_clr;
   logic               w_ready;
   logic               w_wlast;
   logic [NB_DATA-1:0] w_word;
   logic [CW-1:0]      w_wcnt_inc;

   assign w_valid    = bus.i_rx_valid;
   assign w_byte     = bus.i_rx_data;
   assign w_wcnt_inc = r_wcnt + CW'(1);
   assign w_wlast    = (w_wcnt_inc == r_n);

   cpu_loader_word_asm #(
      .NB_DATA (NB_DATA)
   ) u_asm (
      .clk          (clk),
      .i_rst_n      (i_rst_n),
      .i_clr        (w_clr),
      .i_push       (w_push),
      .i_byte       (w_byte),
      .o_word       (w_word),
      .o_word_ready (w_ready)
   );

   // Next-state and one-cycle control decode.
   always_comb begin
      w_next = r_state;
      w_done = 1'b0;
      w_err  = 1'b0;
      w_push = 1'b0;
      w_clr  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_valid) begin
               case (w_byte)
                  CMD_LOAD: w_next = LOAD_CNT;
                  CMD_RUN:  w_next = RUN;
                  CMD_STEP: w_next = STEP;
                  CMD_RST:  w_next = CPU_RST;
                  default:  w_err  = 1'b1;
               endcase
            end
         end
         LOAD_CNT: begin
            if (w_valid) begin
               if (cnt_ok(w_byte, DEPTH)) begin
                  w_clr  = 1'b1;
                  w_next = LOAD_DATA;
               end else begin
                  w_err  = 1'b1;
                  w_next = IDLE;
               end
            end
         end
         LOAD_DATA: begin
            if (w_valid) begin
               w_push = 1'b1;
               if (w_ready) w_next = WRITE;
            end
         end
         WRITE: begin
            if (w_wlast) begin
               w_done = 1'b1;
               w_next = IDLE;
            end else begin
               w_next = LOAD_DATA;
               if (w_valid) begin
                  w_push = 1'b1;
                  if (w_ready) w_next = WRITE;
               end
            end
         end
         RUN: begin
            if (i_cpu_halt ||
                (w_valid && w_byte == CMD_HALT)) begin
               w_done = 1'b1;
               w_next = IDLE;
            end
         end
         STEP: begin
            w_done = 1'b1;
            w_next = IDLE;
         end
         CPU_RST: begin
            if (r_rcnt == RW'(RST_CYCLES - 1)) begin
               w_done = 1'b1;
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // State, counters, pulses and the write-port holding registers.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= IDLE;
         r_n          <= '0;
         r_wcnt       <= '0;
         r_rcnt       <= '0;
         r_imem_data  <= '0;
         r_imem_waddr <= '0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= w_done;
         r_err   <= w_err;
         if (w_clr) begin
            r_n    <= CW'(w_byte);
            r_wcnt <= '0;
         end else if (r_state == WRITE) begin
            r_wcnt <= w_wcnt_inc;
         end
         if (w_push && w_ready) begin
            r_imem_data  <= w_word;
            r_imem_waddr <= (r_state == WRITE) ?
                            w_wcnt_inc[IMEM_ADDR_WIDTH-1:0] :
                            r_wcnt[IMEM_ADDR_WIDTH-1:0];
         end
         if (r_state == CPU_RST) r_rcnt <= r_rcnt + RW'(1);
         else                    r_rcnt <= '0;
      end
   end

   assign bus.o_imem_data  = r_imem_data;
   assign bus.o_imem_waddr = r_imem_waddr;
   assign bus.o_imem_wen   = (r_state == WRITE);
   assign bus.o_mem_wsize  = WSIZE_WORD;

   assign o_cpu_en  = (r_state == RUN) || (r_state == STEP);
   assign o_cpu_rst = (r_state == CPU_RST);
   assign o_busy    = (r_state != IDLE);
   assign o_done    = r_done;
   assign o_err     = r_err;

endmodule

// File: tb/tb_cpu_loader_ctrl.sv
// Self-checking bench for cpu_loader_ctrl.
// Cycle vectors plus directed multi-cycle sequences.
module tb_cpu_loader_ctrl;
   import cpu_loader_pkg::*;

   typedef struct packed {
      logic        wen;
      logic [4:0]  a;
      logic [31:0] d;
      logic        en;
      logic        rst;
      logic        busy;
      logic        done;
      logic        err;
      logic [1:0]  ws;
   } outs_t;

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       h;
      outs_t      e;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic halt = 1'b0;
   logic cpu_en, cpu_rst, busy, done, err;
   outs_t w_out;
   vec_t vecs[$];
   int n_vec = 0;
   int n_bad = 0;

   cpu_loader_ctrl_if #(.NB_DATA(32), .IMEM_ADDR_WIDTH(5)) bus ();

   cpu_loader_ctrl #(
      .NB_DATA         (32),
      .IMEM_ADDR_WIDTH (5),
      .RST_CYCLES      (4)
   ) dut (
      .clk        (clk),
      .i_rst_n    (rst_n),
      .bus        (bus),
      .i_cpu_halt (halt),
      .o_cpu_en   (cpu_en),
      .o_cpu_rst  (cpu_rst),
      .o_busy     (busy),
      .o_done     (done),
      .o_err      (err)
   );

   always #5 clk = ~clk;

   assign w_out = {bus.o_imem_wen, bus.o_imem_waddr,
                   bus.o_imem_data, cpu_en, cpu_rst,
                   busy, done, err, bus.o_mem_wsize};

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
      end
   endtask

   task automatic add(input logic v, input logic [7:0] d,
                      input logic h, input logic wen,
                      input logic [4:0] a,
                      input logic [31:0] wd,
                      input logic en, input logic rs,
                      input logic bz, input logic dn,
                      input logic er);
      vec_t t;
      t.v = v;
      t.d = d;
      t.h = h;
      t.e = {wen, a, wd, en, rs, bz, dn, er, WSIZE_WORD};
      vecs.push_back(t);
   endtask

   task automatic send(input logic [7:0] b);
      bus.i_rx_valid = 1'b1;
      bus.i_rx_data  = b;
      @(posedge clk);
      #1;
      bus.i_rx_valid = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_word(input int w);
      logic [7:0] b;
      b = 8'(w);
      return {b, ~b, 8'h5A, b + 8'h10};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      outs_t z;
      int nw;
      int nd;
      int en_c;
      int last_a;
      logic [31:0] word;

      bus.i_rx_valid = 1'b0;
      bus.i_rx_data  = 8'h00;
      z    = '0;
      z.ws = WSIZE_WORD;

      repeat (3) @(posedge clk);
      #1;
      chk("reset state", 64'(w_out), 64'(z));
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      // v d h | wen a data | en rst busy done err
      add(1, CMD_STEP, 0, 0, 0, 0, 1, 0, 1, 0, 0);
      add(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      add(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 8'h5A, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, CMD_RST, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      add(1, CMD_LOAD, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      add(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      add(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      add(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      add(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, CMD_LOAD, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(1, 8'h02, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(1, 8'h13, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(1, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(1, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(1, 8'h00, 0, 1, 0, 32'h13, 0, 0, 1, 0, 0);
      add(1, 8'h93, 0, 0, 0, 32'h13, 0, 0, 1, 0, 0);
      add(1, 8'h00, 0, 0, 0, 32'h13, 0, 0, 1, 0, 0);
      add(1, 8'h10, 0, 0, 0, 32'h13, 0, 0, 1, 0, 0);
      add(1, 8'h00, 0, 1, 1, 32'h00100093, 0, 0, 1, 0, 0);
      add(0, 8'h00, 0, 0, 1, 32'h00100093, 0, 0, 0, 1, 0);
      add(0, 8'h00, 0, 0, 1, 32'h00100093, 0, 0, 0, 0, 0);
      add(1, CMD_LOAD, 0, 0, 1, 32'h00100093, 0, 0, 1, 0, 0);
      add(1, 8'h00, 0, 0, 1, 32'h00100093, 0, 0, 0, 0, 1);
      add(1, CMD_LOAD, 0, 0, 1, 32'h00100093, 0, 0, 1, 0, 0);
      add(1, 8'h21, 0, 0, 1, 32'h00100093, 0, 0, 0, 0, 1);
      add(0, 8'h00, 0, 0, 1, 32'h00100093, 0, 0, 0, 0, 0);
      add(1, CMD_RUN, 1, 0, 1, 32'h00100093, 1, 0, 1, 0, 0);
      add(0, 8'h00, 1, 0, 1, 32'h00100093, 0, 0, 0, 1, 0);
      add(0, 8'h00, 0, 0, 1, 32'h00100093, 0, 0, 0, 0, 0);
      add(1, CMD_RUN, 0, 0, 1, 32'h00100093, 1, 0, 1, 0, 0);
      add(1, 8'h41, 0, 0, 1, 32'h00100093, 1, 0, 1, 0, 0);
      add(1, CMD_HALT, 1, 0, 1, 32'h00100093, 0, 0, 0, 1, 0);
      add(0, 8'h00, 0, 0, 1, 32'h00100093, 0, 0, 0, 0, 0);

      foreach (vecs[i]) begin
         bus.i_rx_valid = vecs[i].v;
         bus.i_rx_data  = vecs[i].d;
         halt           = vecs[i].h;
         tick();
         chk($sformatf("vec%0d", i), 64'(w_out),
             64'(vecs[i].e));
      end
      bus.i_rx_valid = 1'b0;
      halt = 1'b0;

      // Run terminated by the halt level after 10 cycles.
      send(CMD_RUN);
      en_c = 0;
      nd = 0;
      for (int c = 1; c <= 20; c++) begin
         en_c += int'(cpu_en);
         nd   += int'(done);
         halt = (c >= 10);
         tick();
      end
      halt = 1'b0;
      chk("run halt en cycles", 64'(en_c), 64'd10);
      chk("run halt done", 64'(nd), 64'd1);
      chk("run halt busy", 64'(busy), 64'd0);

      // Run aborted by an 'H' byte; other bytes ignored.
      send(CMD_RUN);
      en_c = 0;
      nd = 0;
      for (int c = 1; c <= 20; c++) begin
         en_c += int'(cpu_en);
         nd   += int'(done);
         bus.i_rx_valid = (c == 5) || (c == 10);
         bus.i_rx_data  = (c == 10) ? CMD_HALT : CMD_STEP;
         tick();
      end
      bus.i_rx_valid = 1'b0;
      chk("run abort en cycles", 64'(en_c), 64'd10);
      chk("run abort done", 64'(nd), 64'd1);
      chk("run abort busy", 64'(busy), 64'd0);

      // Full-depth load: 32 words, back-to-back bytes.
      send(CMD_LOAD);
      send(8'h20);
      nw = 0;
      nd = 0;
      last_a = -1;
      for (int w = 0; w < 33; w++) begin
         for (int k = 0; k < 4; k++) begin
            if (w < 32) begin
               word = exp_word(w);
               send(word[8*k +: 8]);
            end else begin
               tick();
            end
            if (bus.o_imem_wen) begin
               chk($sformatf("load32 word%0d", nw),
                   64'({bus.o_imem_waddr, bus.o_imem_data}),
                   64'({5'(nw), exp_word(nw)}));
               last_a = int'(bus.o_imem_waddr);
               nw++;
            end
            nd += int'(done);
         end
      end
      chk("load32 writes", 64'(nw), 64'd32);
      chk("load32 last addr", 64'(last_a), 64'd31);
      chk("load32 done", 64'(nd), 64'd1);
      chk("load32 busy", 64'(busy), 64'd0);

      // Reset in the middle of a load discards the partial word.
      nw = 0;
      send(CMD_LOAD);
      nw += int'(bus.o_imem_wen);
      send(8'h01);
      nw += int'(bus.o_imem_wen);
      send(8'hAA);
      nw += int'(bus.o_imem_wen);
      send(8'hBB);
      nw += int'(bus.o_imem_wen);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("async reset outs", 64'(w_out), 64'(z));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("partial no write", 64'(nw), 64'd0);
      send(CMD_LOAD);
      send(8'h01);
      send(8'h11);
      send(8'h22);
      send(8'h33);
      chk("reload no early wen", 64'(bus.o_imem_wen), 64'd0);
      send(8'h44);
      chk("reload write",
          64'({bus.o_imem_wen, bus.o_imem_waddr,
               bus.o_imem_data}),
          64'({1'b1, 5'd0, 32'h44332211}));
      tick();
      chk("reload done", 64'({done, busy, bus.o_imem_wen}),
          64'(3'b100));

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
